line_burst_responder: RTL and testbench

- RAM-side responder for the 256-byte cache-line burst interface driven by the cache controller (24-bit line address, ram_rd/ram_wr level requests, ram_get/ram_put word strobes, 16-bit data).
- Expands each line request into 128 single-word accesses on a simple req/ack word memory port, and produces the get/put strobes the cache counts.
- Sits in the ram_clk domain between the cache controller and the SDRAM/SRAM word controller.

---
 rtl/line_burst_responder_if.sv | 27 ++
 rtl/line_burst_responder.sv | 188 ++++++++++++++++++
 tb/tb_line_burst_responder.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/line_burst_responder_if.sv
// Word memory port between the line burst responder (master) and the word controller (slave).
interface line_burst_responder_if;
    logic [30:0] mem_addr_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [15:0] mem_wdata_o;
    logic [15:0] mem_rdata_i;
    logic        mem_ack_i;

    modport master (
        output mem_addr_o,
        output mem_req_o,
        output mem_we_o,
        output mem_wdata_o,
        input  mem_rdata_i,
        input  mem_ack_i
    );

    modport slave (
        input  mem_addr_o,
        input  mem_req_o,
        input  mem_we_o,
        input  mem_wdata_o,
        output mem_rdata_i,
        output mem_ack_i
    );
endinterface

// File: rtl/line_burst_responder.sv
// Expands cache-line read/write requests into WORDS single-word accesses with get/put strobes.
// Optional ack timeout with sticky error: define LINE_BURST_TIMEOUT_EN.
module line_burst_responder #(
    parameter int unsigned WORDS   = 128,
    parameter int unsigned SETTLE  = 2,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic                          ram_clk,
    input  logic                          rst,
    input  logic [23:0]                   ram_addr_i,
    input  logic                          ram_rd_i,
    input  logic                          ram_wr_i,
    input  logic [15:0]                   ram_din_i,
    output logic [15:0]                   ram_dout_o,
    output logic                          ram_get_o,
    output logic                          ram_put_o,
    line_burst_responder_if.master        mem,
    output logic                          busy_o,
    output logic                          err_o
);

    localparam int unsigned WL = $clog2(WORDS);
    localparam int unsigned SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [2:0] {
        StIdle, StRreq, StRget, StWsettle, StWcap, StWreq, StHold
    } state_e;

    state_e      state_q;
    logic [23:0] line_q;
    logic [WL:0] word_q;
    logic [SW-1:0] settle_q;
    logic [15:0] dout_q;
    logic        get_q;
    logic        put_q;
    logic        req_q;
    logic        we_q;
    logic [30:0] addr_q;
    logic [15:0] wdata_q;
    logic        busy_q;

    logic [WL:0] word_nxt;
    logic        last_word;
    logic        tmo_hit;

    assign word_nxt  = word_q + 1'b1;
    // Counter carries a spare MSB; only the low bits identify the word within the line.
    assign last_word = (word_q[WL-1:0] == WL'(WORDS - 1));

`ifdef LINE_BURST_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] tmo_q;
    logic          err_q;

    assign tmo_hit = req_q && !mem.mem_ack_i && (tmo_q == TW'(TIMEOUT - 1));
    assign err_o   = err_q;

    always_ff @(posedge ram_clk) begin
        if (rst || !req_q || mem.mem_ack_i || tmo_hit) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_q + 1'b1;
        end
    end

    always_ff @(posedge ram_clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (tmo_hit) begin
            err_q <= 1'b1;
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign err_o   = 1'b0;
`endif

    always_ff @(posedge ram_clk) begin
        if (rst) begin
            state_q  <= StIdle;
            line_q   <= '0;
            word_q   <= '0;
            settle_q <= '0;
            dout_q   <= '0;
            get_q    <= 1'b0;
            put_q    <= 1'b0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            busy_q   <= 1'b0;
        end else begin
            get_q <= 1'b0;
            put_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (ram_wr_i) begin
                        line_q   <= ram_addr_i;
                        settle_q <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= StWsettle;
                    end else if (ram_rd_i) begin
                        line_q  <= ram_addr_i;
                        req_q   <= 1'b1;
                        we_q    <= 1'b0;
                        addr_q  <= 31'({ram_addr_i, word_q[WL-1:0]});
                        busy_q  <= 1'b1;
                        state_q <= StRreq;
                    end
                end
                StRreq: begin
                    if (mem.mem_ack_i) begin
                        dout_q  <= mem.mem_rdata_i;
                        req_q   <= 1'b0;
                        state_q <= StRget;
                    end else if (tmo_hit) begin
                        // Keep the cache's strobe count intact with a recognisable filler word.
                        dout_q  <= 16'hDEAD;
                        req_q   <= 1'b0;
                        state_q <= StRget;
                    end
                end
                StRget: begin
                    get_q <= 1'b1;
                    if (last_word) begin
                        word_q  <= '0;
                        state_q <= StHold;
                    end else begin
                        word_q  <= word_nxt;
                        req_q   <= 1'b1;
                        addr_q  <= 31'({line_q, word_nxt[WL-1:0]});
                        state_q <= StRreq;
                    end
                end
                StWsettle: begin
                    if (settle_q == SW'(SETTLE - 1)) begin
                        settle_q <= '0;
                        put_q    <= 1'b1;
                        state_q  <= StWcap;
                    end else begin
                        settle_q <= settle_q + 1'b1;
                    end
                end
                StWcap: begin
                    wdata_q <= ram_din_i;
                    req_q   <= 1'b1;
                    we_q    <= 1'b1;
                    addr_q  <= 31'({line_q, word_q[WL-1:0]});
                    state_q <= StWreq;
                end
                StWreq: begin
                    if (mem.mem_ack_i || tmo_hit) begin
                        req_q <= 1'b0;
                        we_q  <= 1'b0;
                        if (last_word) begin
                            word_q  <= '0;
                            state_q <= StHold;
                        end else begin
                            word_q   <= word_nxt;
                            settle_q <= '0;
                            state_q  <= StWsettle;
                        end
                    end
                end
                StHold: begin
                    // Absorbs the cache's late request drop so no extra burst starts.
                    word_q <= '0;
                    if (!ram_rd_i && !ram_wr_i) begin
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign ram_dout_o      = dout_q;
    assign ram_get_o       = get_q;
    assign ram_put_o       = put_q;
    assign busy_o          = busy_q;
    assign mem.mem_addr_o  = addr_q;
    assign mem.mem_req_o   = req_q;
    assign mem.mem_we_o    = we_q;
    assign mem.mem_wdata_o = wdata_q;

endmodule

// File: tb/tb_line_burst_responder.sv
// Scoreboard bench for line_burst_responder: cache and word-memory models drive bursts and
// compare every get word and memory write against queued expectations.
module tb_line_burst_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] ram_addr;
    logic        rd;
    logic        wr;
    logic [15:0] din;
    logic [15:0] dout;
    logic        get;
    logic        put;
    logic        busy;
    logic        err;

    always #5 clk = ~clk;

    line_burst_responder_if mem_bus ();

    line_burst_responder #(
        .WORDS   (128),
        .SETTLE  (2),
        .TIMEOUT (15)
    ) dut (
        .ram_clk    (clk),
        .rst        (rst),
        .ram_addr_i (ram_addr),
        .ram_rd_i   (rd),
        .ram_wr_i   (wr),
        .ram_din_i  (din),
        .ram_dout_o (dout),
        .ram_get_o  (get),
        .ram_put_o  (put),
        .mem        (mem_bus),
        .busy_o     (busy),
        .err_o      (err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] exp_rd_q[$];
    logic [46:0] exp_wr_q[$];

    int get_cnt = 0;
    int put_cnt = 0;
    int wr_cnt  = 0;
    int cyc     = 0;
    int last_put_cyc = 0;
    int din_dly = 0;
    int mem_delay = 0;
    int wcnt = 0;
    bit no_ack7 = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Cache model: counts strobes, checks data, presents the next write word 2 cycles after put.
    always @(negedge clk) begin
        if (get) begin
            get_cnt++;
            if (exp_rd_q.size() == 0) check_eq("extra_get", get_cnt, 0);
            else check_eq("get_data", dout, exp_rd_q.pop_front());
        end
        if (put) begin
            if (put_cnt > 0) check_eq("put_spacing", 64'((cyc - last_put_cyc) >= 4), 1);
            last_put_cyc = cyc;
            put_cnt++;
            din_dly = 2;
        end else if (din_dly > 0) begin
            din_dly--;
            if (din_dly == 0) din = 16'h1000 + 16'(put_cnt);
        end
    end

    // Word memory model: data = low 16 bits of the word address, optional wait states.
    always @(negedge clk) begin
        mem_bus.mem_ack_i = 1'b0;
        if (rst || !mem_bus.mem_req_o) begin
            wcnt = 0;
        end else if (!(no_ack7 && !mem_bus.mem_we_o && mem_bus.mem_addr_o[6:0] == 7'd7)) begin
            if (wcnt >= mem_delay) begin
                mem_bus.mem_ack_i   = 1'b1;
                mem_bus.mem_rdata_i = mem_bus.mem_addr_o[15:0];
                wcnt = 0;
                if (mem_bus.mem_we_o) begin
                    wr_cnt++;
                    if (exp_wr_q.size() == 0) check_eq("extra_write", wr_cnt, 0);
                    else check_eq("write_addr_data", {mem_bus.mem_addr_o, mem_bus.mem_wdata_o},
                                  exp_wr_q.pop_front());
                end
            end else begin
                wcnt++;
            end
        end
    end

    task automatic start_read(input logic [23:0] line);
        for (int k = 0; k < 128; k++) begin
            logic [30:0] wa;
            wa = {line, 7'(k)};
            exp_rd_q.push_back(wa[15:0]);
        end
        get_cnt  = 0;
        ram_addr = line;
        rd       = 1'b1;
    endtask

    task automatic wait_gets(input int n, input string tag);
        int b = 0;
        while (get_cnt < n && b < 3000) begin
            tick;
            b++;
        end
        check_eq(tag, get_cnt, n);
    endtask

    task automatic run_write(input logic [23:0] line, input bit also_rd);
        int b;
        int gets_before;
        gets_before = get_cnt;
        put_cnt = 0;
        wr_cnt  = 0;
        din_dly = 0;
        din     = 16'h1000;
        for (int k = 0; k < 128; k++) begin
            exp_wr_q.push_back({line, 7'(k), 16'h1000 + 16'(k)});
        end
        ram_addr = line;
        wr       = 1'b1;
        rd       = also_rd;
        b = 0;
        while (!mem_bus.mem_req_o && b < 100) begin
            tick;
            b++;
        end
        check_eq("first_req_we", mem_bus.mem_we_o, 1);
        b = 0;
        while (wr_cnt < 128 && b < 5000) begin
            tick;
            b++;
        end
        check_eq("write_count", wr_cnt, 128);
        tick;
        wr = 1'b0;
        rd = 1'b0;
        tick;
        check_eq("put_count", put_cnt, 128);
        check_eq("write_busy_idle", busy, 0);
        check_eq("write_sb_empty", exp_wr_q.size(), 0);
        check_eq("write_no_gets", get_cnt, gets_before);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_outs"}, {busy, get, put, err, mem_bus.mem_req_o, mem_bus.mem_we_o}, 0);
        check_eq({tag, "_dout"}, dout, 0);
        check_eq({tag, "_addr"}, mem_bus.mem_addr_o, 0);
        check_eq({tag, "_wdata"}, mem_bus.mem_wdata_o, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rd = 1'b0;
        wr = 1'b0;
        din = 16'h1000;
        ram_addr = '0;
        rst = 1'b1;
        repeat (3) tick;
        check_all_zero("reset");
        rst = 1'b0;
        tick;

        // Zero-wait read burst, then rd held 5 cycles in HOLD.
        start_read(24'h000012);
        wait_gets(128, "read_gets");
        repeat (5) tick;
        check_eq("hold_no_extra_get", get_cnt, 128);
        check_eq("hold_busy", busy, 1);
        rd = 1'b0;
        tick;
        check_eq("read_busy_idle", busy, 0);
        check_eq("read_sb_empty", exp_rd_q.size(), 0);

        // Write burst, then rd and wr rising together (write must win).
        run_write(24'h0000A5, 1'b0);
        tick;
        run_write(24'h00003C, 1'b1);
        tick;

        // Reset mid-read with slow memory, then a fresh read from word 0.
        mem_delay = 3;
        start_read(24'h000040);
        wait_gets(41, "pre_reset_gets");
        rst = 1'b1;
        rd  = 1'b0;
        tick;
        check_all_zero("midreset");
        exp_rd_q.delete();
        rst = 1'b0;
        mem_delay = 0;
        tick;
        check_eq("post_reset_no_get", get_cnt, 41);
        start_read(24'h000041);
        wait_gets(128, "restart_gets");
        rd = 1'b0;
        tick;
        check_eq("restart_sb_empty", exp_rd_q.size(), 0);

`ifdef LINE_BURST_TIMEOUT_EN
        // Memory never acks word 7: filler word, sticky error, full strobe count.
        check_eq("err_before", err, 0);
        no_ack7 = 1'b1;
        start_read(24'h000033);
        exp_rd_q[7] = 16'hDEAD;
        wait_gets(128, "timeout_gets");
        check_eq("err_set", err, 1);
        rd = 1'b0;
        repeat (3) tick;
        check_eq("err_sticky", err, 1);
        check_eq("timeout_sb_empty", exp_rd_q.size(), 0);
        no_ack7 = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
